// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-slot alarm controller running on the 1 Hz tick.
// Holds NUM_ALARMS alarm times. Each time has an armed bit. Every alarm time is
// compared against the running BCD clock, and a ring/snooze FSM drives the
// registered alarm output.
// Optional feature macro: SNOOZE_EN. When it is defined, the snooze input, the
// SNOOZE state and the snooze counter are built. When it is undefined, the
// snooze input is ignored and the SNOOZE state cannot be reached.
module alarm_scheduler #(
   parameter  int NUM_ALARMS       = 4,
   parameter  int SNOOZE_SEC       = 300,
   parameter  int RING_TIMEOUT_SEC = 60,
   localparam int SW               = $clog2(NUM_ALARMS)
) (
   input  logic          clk_1s,
   input  logic          areset,
   input  logic [13:0]   cur_hm,
   input  logic [7:0]    cur_sec,
   input  logic          wr_en,
   input  logic [SW-1:0] wr_slot,
   input  logic [13:0]   wr_time,
   input  logic          wr_arm,
   input  logic          al_on,
   input  logic          stop,
   input  logic          snooze,
   output logic          alarm,
   output logic [SW-1:0] active_slot,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } state_t;

   localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_SEC - 1);

   logic [13:0]           slot_time_r [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] slot_arm_r;
   logic                  wr_valid_s;
   logic                  match_any_s;
   logic [SW-1:0]         match_idx_s;

   state_t                state_r;
   state_t                next_state_s;
   logic [7:0]            ring_cnt_r;
   logic [7:0]            next_ring_cnt_s;
   logic [SW-1:0]         active_slot_r;
   logic [SW-1:0]         next_active_s;
   logic                  alarm_r;

`ifdef SNOOZE_EN
   localparam logic [8:0] SNZ_LOAD = 9'(SNOOZE_SEC - 1);
   logic [8:0]            snz_cnt_r;
   logic [8:0]            next_snz_cnt_s;
`else
   // The snooze input and duration have no function in this build.
   logic [9:0]            snooze_unused_s;
   assign snooze_unused_s = {snooze, 9'(SNOOZE_SEC)};
`endif

   // Slot indices past the configured count are dropped. This only matters
   // when NUM_ALARMS is not a power of two.
   assign wr_valid_s = (int'(wr_slot) < NUM_ALARMS);

   // Slot storage: load the time and armed flag of one slot on a valid write strobe.
   always_ff @(posedge clk_1s or posedge areset) begin
      if (areset) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            slot_time_r[i] <= 14'h0000;
         end
         slot_arm_r <= '0;
      end else if (wr_en && wr_valid_s) begin
         slot_time_r[wr_slot] <= wr_time;
         slot_arm_r[wr_slot]  <= wr_arm;
      end
   end

   // Match detect: find the lowest-index armed slot equal to hh:mm:00 while enabled.
   always_comb begin
      match_any_s = 1'b0;
      match_idx_s = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (slot_arm_r[i] && (slot_time_r[i] == cur_hm) && (cur_sec == 8'h00) && al_on) begin
            match_any_s = 1'b1;
            match_idx_s = SW'(i);
         end else begin
            match_any_s = match_any_s;
            match_idx_s = match_idx_s;
         end
      end
   end

   // Next-state logic: move between IDLE, RING and SNOOZE and update the counters.
   always_comb begin
      next_state_s    = state_r;
      next_ring_cnt_s = ring_cnt_r;
      next_active_s   = active_slot_r;
`ifdef SNOOZE_EN
      next_snz_cnt_s  = snz_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            // A stop in this state has no effect, so a match at the same edge starts a ring.
            if (match_any_s) begin
               next_state_s    = ST_RING;
               next_active_s   = match_idx_s;
               next_ring_cnt_s = 8'd0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RING: begin
            if (stop || !al_on) begin
               next_state_s = ST_IDLE;
`ifdef SNOOZE_EN
            end else if (snooze) begin
               next_state_s   = ST_SNOOZE;
               next_snz_cnt_s = SNZ_LOAD;
`endif
            end else if (ring_cnt_r == RING_LAST) begin
               next_state_s = ST_IDLE;
            end else begin
               next_ring_cnt_s = ring_cnt_r + 8'd1;
            end
         end
         ST_SNOOZE: begin
`ifdef SNOOZE_EN
            // A snooze request in this state is ignored.
            if (stop || !al_on) begin
               next_state_s = ST_IDLE;
            end else if (snz_cnt_r == 9'd0) begin
               next_state_s    = ST_RING;
               next_ring_cnt_s = 8'd0;
            end else begin
               next_snz_cnt_s = snz_cnt_r - 9'd1;
            end
`else
            next_state_s = ST_IDLE;
`endif
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register: alarm is taken from the next state, so it has no glitches and shows
   // the same edge.
   always_ff @(posedge clk_1s or posedge areset) begin
      if (areset) begin
         state_r       <= ST_IDLE;
         ring_cnt_r    <= 8'd0;
         active_slot_r <= '0;
         alarm_r       <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         ring_cnt_r    <= next_ring_cnt_s;
         active_slot_r <= next_active_s;
         alarm_r       <= (next_state_s == ST_RING);
      end
   end

`ifdef SNOOZE_EN
   // Snooze countdown register.
   always_ff @(posedge clk_1s or posedge areset) begin
      if (areset) begin
         snz_cnt_r <= 9'd0;
      end else begin
         snz_cnt_r <= next_snz_cnt_s;
      end
   end
`endif

   assign alarm       = alarm_r;
   assign active_slot = active_slot_r;
   assign state       = state_r;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed self-checking bench for alarm_scheduler (default parameters).
// The snooze scenarios follow the SNOOZE_EN macro, in the same way as the design.
module tb_alarm_scheduler;

   logic        clk_1s;
   logic        areset;
   logic [13:0] cur_hm;
   logic [7:0]  cur_sec;
   logic        wr_en;
   logic [1:0]  wr_slot;
   logic [13:0] wr_time;
   logic        wr_arm;
   logic        al_on;
   logic        stop;
   logic        snooze;
   logic        alarm;
   logic [1:0]  active_slot;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;

   alarm_scheduler dut (
      .clk_1s      (clk_1s),
      .areset      (areset),
      .cur_hm      (cur_hm),
      .cur_sec     (cur_sec),
      .wr_en       (wr_en),
      .wr_slot     (wr_slot),
      .wr_time     (wr_time),
      .wr_arm      (wr_arm),
      .al_on       (al_on),
      .stop        (stop),
      .snooze      (snooze),
      .alarm       (alarm),
      .active_slot (active_slot),
      .state       (state)
   );

   initial clk_1s = 1'b0;
   always #5 clk_1s = ~clk_1s;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_1s);
      #1;
   endtask

   task automatic write_slot(input logic [1:0] s, input logic [13:0] t, input logic a);
      wr_en   = 1'b1;
      wr_slot = s;
      wr_time = t;
      wr_arm  = a;
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      areset  = 1'b1;
      cur_hm  = 14'h0000;
      cur_sec = 8'h00;
      wr_en   = 1'b0;
      wr_slot = 2'd0;
      wr_time = 14'h0000;
      wr_arm  = 1'b0;
      al_on   = 1'b1;
      stop    = 1'b0;
      snooze  = 1'b0;
      #12;
      check("rst_alarm", 32'(alarm), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_slot", 32'(active_slot), 32'd0);
      areset = 1'b0;

      // Slots come out of reset at 00:00 and disarmed: no ring at 00:00:00.
      step();
      check("disarmed_rst", 32'(state), 32'd0);

      // Slot 1 = 07:30 armed, full 60-cycle ring.
      cur_sec = 8'h30;
      write_slot(2'd1, 14'h0730, 1'b1);
      cur_hm  = 14'h0730;
      cur_sec = 8'h59;
      step();
      check("sec59_noring", 32'(state), 32'd0);
      cur_sec = 8'h00;
      step();
      check("ring1_alarm", 32'(alarm), 32'd1);
      check("ring1_slot", 32'(active_slot), 32'd1);
      check("ring1_state", 32'(state), 32'd1);
      cur_sec = 8'h01;
      for (int k = 1; k < 60; k++) begin
         step();
         check("ring1_hold", 32'(alarm), 32'd1);
      end
      step();
      check("timeout_alarm", 32'(alarm), 32'd0);
      check("timeout_state", 32'(state), 32'd0);

      // Slots 0 and 2 at 06:00, slot 3 disarmed at 05:00.
      cur_sec = 8'h30;
      write_slot(2'd0, 14'h0600, 1'b1);
      write_slot(2'd2, 14'h0600, 1'b1);
      write_slot(2'd3, 14'h0500, 1'b0);
      cur_hm  = 14'h0500;
      cur_sec = 8'h00;
      step();
      check("slot3_disarmed", 32'(state), 32'd0);
      cur_hm = 14'h0600;
      step();
      check("prio_state", 32'(state), 32'd1);
      check("prio_slot", 32'(active_slot), 32'd0);
      cur_sec = 8'h01;
      write_slot(2'd2, 14'h0700, 1'b1);
      check("wr_in_ring_state", 32'(state), 32'd1);
      check("wr_in_ring_slot", 32'(active_slot), 32'd0);
      stop = 1'b1;
      step();
      check("stop_alarm", 32'(alarm), 32'd0);
      check("stop_state", 32'(state), 32'd0);
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("one_ring_only", 32'(state), 32'd0);
      end
      check("slot_hold_idle", 32'(active_slot), 32'd0);

      // Stop and match on the same edge in IDLE: the match wins.
      cur_hm  = 14'h0730;
      cur_sec = 8'h00;
      stop    = 1'b1;
      step();
      check("stop_vs_match_state", 32'(state), 32'd1);
      check("stop_vs_match_slot", 32'(active_slot), 32'd1);
      stop    = 1'b0;
      cur_sec = 8'h01;
      for (int k = 0; k < 4; k++) begin
         step();
      end
      stop = 1'b1;
      step();
      check("stop_c5_alarm", 32'(alarm), 32'd0);
      stop = 1'b0;
      for (int t = 0; t < 6; t++) begin
         for (int o = 0; o < 10; o++) begin
            if ((t != 0) || (o != 0)) begin
               cur_sec = {4'(t), 4'(o)};
               step();
               check("no_retrigger", 32'(state), 32'd0);
            end
         end
      end

      // al_on dropped during RING.
      cur_sec = 8'h00;
      step();
      check("alon_ring_start", 32'(state), 32'd1);
      cur_sec = 8'h01;
      step();
      step();
      al_on = 1'b0;
      step();
      check("alon_ring_state", 32'(state), 32'd0);
      check("alon_ring_alarm", 32'(alarm), 32'd0);
      al_on = 1'b1;

`ifdef SNOOZE_EN
      // Snooze at ring cycle 3, re-ring 300 edges later. Snooze is held high throughout
      // to show that it is ignored while snoozing.
      cur_sec = 8'h00;
      step();
      cur_sec = 8'h01;
      for (int k = 0; k < 3; k++) begin
         step();
      end
      snooze = 1'b1;
      step();
      check("snz_alarm", 32'(alarm), 32'd0);
      check("snz_state", 32'(state), 32'd2);
      for (int k = 1; k < 300; k++) begin
         step();
      end
      check("snz_299_alarm", 32'(alarm), 32'd0);
      check("snz_299_state", 32'(state), 32'd2);
      step();
      check("snz_300_alarm", 32'(alarm), 32'd1);
      check("snz_300_state", 32'(state), 32'd1);
      step();
      check("snz2_state", 32'(state), 32'd2);
      snooze = 1'b0;
      for (int k = 1; k < 300; k++) begin
         step();
      end
      check("snz2_299_alarm", 32'(alarm), 32'd0);
      step();
      check("snz2_300_alarm", 32'(alarm), 32'd1);
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      check("snz3_state", 32'(state), 32'd2);
      for (int k = 0; k < 5; k++) begin
         step();
      end
      stop = 1'b1;
      step();
      check("snz_stop_state", 32'(state), 32'd0);
      check("snz_stop_alarm", 32'(alarm), 32'd0);
      stop = 1'b0;

      // al_on dropped during SNOOZE.
      cur_sec = 8'h00;
      step();
      cur_sec = 8'h01;
      snooze  = 1'b1;
      step();
      snooze = 1'b0;
      check("snz_alon_pre", 32'(state), 32'd2);
      step();
      step();
      al_on = 1'b0;
      step();
      check("snz_alon_state", 32'(state), 32'd0);
      check("snz_alon_alarm", 32'(alarm), 32'd0);
      al_on = 1'b1;
`else
      // Without the snooze feature, snooze is ignored and the ring still lasts 60 cycles.
      cur_sec = 8'h00;
      step();
      cur_sec = 8'h01;
      snooze  = 1'b1;
      for (int k = 1; k < 4; k++) begin
         step();
         check("snz_ignored_state", 32'(state), 32'd1);
         check("snz_ignored_alarm", 32'(alarm), 32'd1);
      end
      snooze = 1'b0;
      for (int k = 4; k < 60; k++) begin
         step();
      end
      check("nosnz_59_alarm", 32'(alarm), 32'd1);
      step();
      check("nosnz_timeout", 32'(state), 32'd0);
`endif

      // Asynchronous reset mid-ring clears the state and the slot contents.
      cur_sec = 8'h00;
      step();
      check("rst_ring_pre", 32'(state), 32'd1);
      cur_sec = 8'h01;
      step();
      step();
      #2;
      areset = 1'b1;
      #1;
      check("arst_alarm", 32'(alarm), 32'd0);
      check("arst_state", 32'(state), 32'd0);
      check("arst_slot", 32'(active_slot), 32'd0);
      #1;
      areset  = 1'b0;
      cur_sec = 8'h00;
      step();
      check("arst_slots_lost", 32'(state), 32'd0);
      check("arst_slots_alarm", 32'(alarm), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
